// File: rtl/modeselect_bank.sv
// Limit-preset bank for a BCD counter: stores per-slot limits and drives
// single / carry / max mode outputs from the selected slot, all registered.
module modeselect_bank #(
   parameter  int DIGITS = 6,
   parameter  int SLOTS  = 4,
   localparam int SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1,
   localparam int DW     = 4 * DIGITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] cnt_in,
   input  logic [1:0]    mode_req,
   input  logic [SW-1:0] rd_slot,
   input  logic          store,
   input  logic [SW-1:0] wr_slot,
   input  logic          clear_all,
   output logic [DW-1:0] max_out,
   output logic          carry_en,
   output logic          max_en,
   output logic          hit,
   output logic          store_ack,
   output logic          store_err,
   output logic          mode_err
);

   typedef enum logic [1:0] {SINGLE, CARRY, MAX, GAP} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   lim_q [SLOTS];
   logic [DW-1:0]   lim_d [SLOTS];
   logic [SLOTS-1:0] vld_q, vld_d;

   logic [DW-1:0]   max_out_q, max_out_d;
   logic            carry_en_q, carry_en_d;
   logic            max_en_q, max_en_d;
   logic            hit_q, hit_d;
   logic            store_ack_q, store_ack_d;
   logic            store_err_q, store_err_d;
   logic            mode_err_q, mode_err_d;

   logic [DW-1:0]     rd_lim;
   logic              rd_vld;
   logic              req_carry, req_max;
   logic [DW-1:0]     carry_map;
   logic [DIGITS-1:0] digit_bad;
   logic              cnt_bad;

   // Per-digit decode: carry flag of the selected limit and BCD validity of cnt_in.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign carry_map[4*gi]         = |rd_lim[4*gi +: 4];
         assign carry_map[4*gi+3:4*gi+1] = 3'b000;
         assign digit_bad[gi]           = (cnt_in[4*gi +: 4] > 4'd9);
      end
   endgenerate

   assign cnt_bad = |digit_bad;

   always_comb begin
      rd_lim    = lim_q[rd_slot];
      rd_vld    = vld_q[rd_slot];
      req_carry = (mode_req == 2'b01);
      req_max   = (mode_req == 2'b10);

      state_d = SINGLE;
      case (state_q)
         CARRY: begin
            if (rd_vld && req_carry)    state_d = CARRY;
            else if (rd_vld && req_max) state_d = GAP;
         end
         MAX: begin
            if (rd_vld && req_max)        state_d = MAX;
            else if (rd_vld && req_carry) state_d = GAP;
         end
         default: begin
            if (rd_vld && req_carry)    state_d = CARRY;
            else if (rd_vld && req_max) state_d = MAX;
         end
      endcase

      max_out_d = '0;
      case (state_d)
         CARRY:   max_out_d = carry_map;
         MAX:     max_out_d = rd_lim;
         default: max_out_d = '0;
      endcase

      carry_en_d = (state_d == CARRY);
      max_en_d   = (state_d == MAX);
      hit_d      = (state_d == MAX) && (cnt_in == rd_lim);
      mode_err_d = (req_carry || req_max) && !rd_vld;
   end

   // Slot update: clear_all overrides any store in the same cycle.
   always_comb begin
      lim_d       = lim_q;
      vld_d       = vld_q;
      store_ack_d = 1'b0;
      store_err_d = 1'b0;
      if (clear_all) begin
         vld_d = '0;
      end else if (store) begin
         if (cnt_bad) begin
            store_err_d = 1'b1;
         end else begin
            lim_d[wr_slot] = cnt_in;
            vld_d[wr_slot] = 1'b1;
            store_ack_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SINGLE;
         vld_q       <= '0;
         for (int i = 0; i < SLOTS; i++) lim_q[i] <= '0;
         max_out_q   <= '0;
         carry_en_q  <= 1'b0;
         max_en_q    <= 1'b0;
         hit_q       <= 1'b0;
         store_ack_q <= 1'b0;
         store_err_q <= 1'b0;
         mode_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         lim_q       <= lim_d;
         max_out_q   <= max_out_d;
         carry_en_q  <= carry_en_d;
         max_en_q    <= max_en_d;
         hit_q       <= hit_d;
         store_ack_q <= store_ack_d;
         store_err_q <= store_err_d;
         mode_err_q  <= mode_err_d;
      end
   end

   assign max_out   = max_out_q;
   assign carry_en  = carry_en_q;
   assign max_en    = max_en_q;
   assign hit       = hit_q;
   assign store_ack = store_ack_q;
   assign store_err = store_err_q;
   assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_modeselect_bank.sv
// Bench for modeselect_bank: directed scenarios plus randomized traffic,
// each cycle checked against a behavioural model of the preset bank.
module tb_modeselect_bank;
   localparam int DIGITS = 6;
   localparam int SLOTS  = 4;
   localparam int SW     = 2;
   localparam int DW     = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] cnt_in = '0;
   logic [1:0]    mode_req = 2'b00;
   logic [SW-1:0] rd_slot = '0;
   logic          store = 1'b0;
   logic [SW-1:0] wr_slot = '0;
   logic          clear_all = 1'b0;
   logic [DW-1:0] max_out;
   logic          carry_en, max_en, hit, store_ack, store_err, mode_err;

   modeselect_bank #(.DIGITS(DIGITS), .SLOTS(SLOTS)) dut (
      .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .mode_req(mode_req),
      .rd_slot(rd_slot), .store(store), .wr_slot(wr_slot), .clear_all(clear_all),
      .max_out(max_out), .carry_en(carry_en), .max_en(max_en), .hit(hit),
      .store_ack(store_ack), .store_err(store_err), .mode_err(mode_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: 0 single, 1 carry, 2 max, 3 gap
   logic [DW-1:0] m_lim [SLOTS];
   logic          m_vld [SLOTS];
   int            m_mode;
   logic [DW+5:0] exp_v;
   wire  [DW+5:0] obs_v = {max_out, carry_en, max_en, hit, store_ack, store_err, mode_err};

   function automatic bit bcd_ok(input logic [DW-1:0] v);
      for (int k = 0; k < DIGITS; k++)
         if (((v >> (4 * k)) & 'hF) > 9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [DW-1:0] carry_bits(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < DIGITS; k++)
         if (((v >> (4 * k)) & 'hF) != 0) r = r | (DW'(1) << (4 * k));
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      for (int i = 0; i < SLOTS; i++) begin
         m_lim[i] = '0;
         m_vld[i] = 1'b0;
      end
      exp_v = '0;
   endtask

   // Advance one clock: predict outputs from pre-edge model state, then sample 1ns after the edge.
   task automatic tick();
      int want, nxt;
      logic [DW-1:0] lim, o;
      logic vld, ok, ack, err;
      if (!rst_n) begin
         model_reset();
      end else begin
         lim  = m_lim[rd_slot];
         vld  = m_vld[rd_slot];
         want = (mode_req == 2'b01) ? 1 : (mode_req == 2'b10) ? 2 : 0;
         if (want == 0 || !vld) nxt = 0;
         else if ((m_mode == 1 && want == 2) || (m_mode == 2 && want == 1)) nxt = 3;
         else nxt = want;
         o   = (nxt == 2) ? lim : (nxt == 1) ? carry_bits(lim) : '0;
         ok  = bcd_ok(cnt_in);
         ack = store && !clear_all && ok;
         err = store && !clear_all && !ok;
         exp_v = {o, (nxt == 1), (nxt == 2), (nxt == 2) && (cnt_in == lim), ack, err,
                  (want != 0) && !vld};
         if (clear_all) begin
            for (int i = 0; i < SLOTS; i++) m_vld[i] = 1'b0;
         end else if (ack) begin
            m_lim[wr_slot] = cnt_in;
            m_vld[wr_slot] = 1'b1;
         end
         m_mode = nxt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      n_cmp++;
      if (obs_v !== '0) begin
         n_bad++;
         $display("FAIL reset: outputs %h, required 0", obs_v);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("reset done: outputs %h", obs_v);
   endtask

   task automatic test_directed();
      logic [DW-1:0] chk [14];
      logic [7:0]    flg [14];
      string         nm  [14];
      int            idx;
      idx = 0;
      // store 0x000509 to slot 1 while requesting max on slot 1
      cnt_in = 24'h000509; wr_slot = 1; store = 1; rd_slot = 1; mode_req = 2'b10;
      tick(); chk[idx] = max_out; flg[idx] = {2'b0, carry_en, max_en, hit, store_ack, store_err, mode_err};
      nm[idx] = "store_ack"; idx++;
      n_cmp++;
      if (store_ack !== 1'b1 || store_err !== 1'b0) begin
         n_bad++; $display("FAIL store_ack: ack=%b err=%b, required ack=1 err=0", store_ack, store_err);
      end
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL dir_store: got %h want %h", obs_v, exp_v); end
      store = 0; cnt_in = 24'h000508;
      tick();
      n_cmp++;
      if (max_en !== 1'b1 || max_out !== 24'h000509 || hit !== 1'b0 || store_ack !== 1'b0) begin
         n_bad++; $display("FAIL max_mode: max_en=%b max_out=%h hit=%b ack=%b, required 1/000509/0/0",
                           max_en, max_out, hit, store_ack);
      end
      cnt_in = 24'h000509;
      tick();
      n_cmp++;
      if (hit !== 1'b1) begin n_bad++; $display("FAIL hit_rise: hit=%b, required 1", hit); end
      mode_req = 2'b01;
      tick();
      n_cmp++;
      if (carry_en !== 1'b0 || max_en !== 1'b0 || max_out !== '0 || hit !== 1'b0) begin
         n_bad++; $display("FAIL gap: carry=%b max=%b out=%h hit=%b, required all 0", carry_en, max_en, max_out, hit);
      end
      tick();
      n_cmp++;
      if (carry_en !== 1'b1 || max_out !== 24'h000101) begin
         n_bad++; $display("FAIL carry_mode: carry_en=%b max_out=%h, required 1/000101", carry_en, max_out);
      end
      cnt_in = 24'h00A123; store = 1; wr_slot = 1;
      tick();
      n_cmp++;
      if (store_err !== 1'b1 || store_ack !== 1'b0) begin
         n_bad++; $display("FAIL store_err: err=%b ack=%b, required 1/0", store_err, store_ack);
      end
      store = 0; mode_req = 2'b10;
      tick();
      tick();
      n_cmp++;
      if (max_en !== 1'b1 || max_out !== 24'h000509 || store_err !== 1'b0) begin
         n_bad++; $display("FAIL slot_kept: max_en=%b out=%h err=%b, required 1/000509/0", max_en, max_out, store_err);
      end
      rd_slot = 2;
      tick();
      n_cmp++;
      if (mode_err !== 1'b1 || max_en !== 1'b0 || max_out !== '0) begin
         n_bad++; $display("FAIL mode_err: err=%b max_en=%b out=%h, required 1/0/0", mode_err, max_en, max_out);
      end
      cnt_in = 24'h000042; store = 1; wr_slot = 2;
      tick();
      store = 0;
      tick();
      n_cmp++;
      if (max_en !== 1'b1 || max_out !== 24'h000042 || mode_err !== 1'b0) begin
         n_bad++; $display("FAIL late_valid: max_en=%b out=%h merr=%b, required 1/000042/0", max_en, max_out, mode_err);
      end
      rd_slot = 1;
      tick();
      n_cmp++;
      if (max_en !== 1'b1 || max_out !== 24'h000509) begin
         n_bad++; $display("FAIL rd_switch: max_en=%b out=%h, required 1/000509", max_en, max_out);
      end
      clear_all = 1; store = 1; wr_slot = 3; cnt_in = 24'h000509;
      tick();
      n_cmp++;
      if (store_ack !== 1'b0 || store_err !== 1'b0 || obs_v !== exp_v) begin
         n_bad++; $display("FAIL clear_vs_store: got %h want %h", obs_v, exp_v);
      end
      clear_all = 0; store = 0;
      tick();
      n_cmp++;
      if (max_en !== 1'b0 || hit !== 1'b0 || mode_err !== 1'b1) begin
         n_bad++; $display("FAIL clear_all: max_en=%b hit=%b merr=%b, required 0/0/1", max_en, hit, mode_err);
      end
      cnt_in = '0; store = 1; wr_slot = 3; rd_slot = 3;
      tick();
      store = 0;
      tick();
      n_cmp++;
      if (max_en !== 1'b1 || max_out !== '0 || hit !== 1'b1) begin
         n_bad++; $display("FAIL zero_store: max_en=%b out=%h hit=%b, required 1/0/1", max_en, max_out, hit);
      end
      $display("directed: %0d steps logged, outputs %h", idx, obs_v);
   endtask

   task automatic test_random();
      logic [DW-1:0] v;
      for (int c = 0; c < 400; c++) begin
         mode_req  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) rd_slot = SW'($urandom_range(0, SLOTS - 1));
         wr_slot   = SW'($urandom_range(0, SLOTS - 1));
         store     = ($urandom_range(0, 3) == 0);
         clear_all = ($urandom_range(0, 40) == 0);
         v = '0;
         for (int k = 0; k < DIGITS; k++) v = v | (DW'($urandom_range(0, 9)) << (4 * k));
         if ($urandom_range(0, 7) == 0)
            v = v | (DW'($urandom_range(10, 15)) << (4 * $urandom_range(0, DIGITS - 1)));
         cnt_in = ($urandom_range(0, 2) == 0) ? m_lim[rd_slot] : v;
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h want %h", c, obs_v, exp_v);
         end
      end
      store = 0; clear_all = 0;
      $display("random: 400 cycles done");
   endtask

   task automatic test_reset_mid();
      cnt_in = 24'h123456; store = 1; wr_slot = 0; rd_slot = 0; mode_req = 2'b10;
      tick();
      store = 0;
      tick();
      n_cmp++;
      if (max_en !== 1'b1 || max_out !== 24'h123456) begin
         n_bad++; $display("FAIL pre_reset_max: max_en=%b out=%h, required 1/123456", max_en, max_out);
      end
      store = 1; cnt_in = 24'h000777;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs_v !== '0) begin n_bad++; $display("FAIL async_reset: outputs %h, required 0", obs_v); end
      tick();
      tick();
      store = 0;
      #2;
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (store_ack !== 1'b0 || store_err !== 1'b0 || mode_err !== 1'b1 || max_en !== 1'b0 || obs_v !== exp_v) begin
         n_bad++; $display("FAIL post_reset: got %h want %h (ack 0, merr 1)", obs_v, exp_v);
      end
      $display("reset mid-store: outputs %h", obs_v);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/modeselect_bank.md
MODESELECT_BANK -- requirements
Module: modeselect_bank

Interface
REQ-001 Parameter DIGITS, default 6, number of BCD digits handled (1..8).
REQ-002 Parameter SLOTS, default 4, number of stored limit presets (power of two, 2..8); SW = log2(SLOTS).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cnt_in  input  4*DIGITS  current counter value, digit k at bits [4k+3:4k].
REQ-006 mode_req  input  2  requested mode: 00 single, 01 carry, 10 max, 11 treated as 00.
REQ-007 rd_slot  input  SW  slot driving the outputs.
REQ-008 store  input  1  one-cycle request to capture cnt_in into wr_slot.
REQ-009 wr_slot  input  SW  target slot for store.
REQ-010 clear_all  input  1  synchronous invalidation of all slots.
REQ-011 max_out  output  4*DIGITS  limit values (max mode) or per-digit carry bits (carry mode).
REQ-012 carry_en  output  1  carry mode active.
REQ-013 max_en  output  1  max-value mode active.
REQ-014 hit  output  1  cnt_in equals the active limit in max mode.
REQ-015 store_ack  output  1  one-cycle pulse, store accepted.
REQ-016 store_err  output  1  one-cycle pulse, store rejected.
REQ-017 mode_err  output  1  level, requested mode refused because rd_slot is invalid.

Function
REQ-018 Each slot SHALL hold a 4*DIGITS limit and a valid bit; all outputs SHALL be registered.
REQ-019 Mode FSM states: SINGLE, CARRY, MAX, GAP; carry_en=1 only in CARRY, max_en=1 only in MAX, never both.
REQ-020 SINGLE/GAP -> CARRY when mode_req=01 and slot[rd_slot] valid; -> MAX when mode_req=10 and valid; otherwise -> SINGLE.
REQ-021 CARRY -> MAX or MAX -> CARRY SHALL pass through GAP for exactly one cycle (both enables 0, max_out 0).
REQ-022 CARRY or MAX with mode_req=00/11 or slot[rd_slot] invalid SHALL go to SINGLE next cycle.
REQ-023 mode_err SHALL be registered high when mode_req is 01/10 and slot[rd_slot] invalid, else low.
REQ-024 In CARRY, max_out bit 4k SHALL be 1 iff digit k of slot[rd_slot] is nonzero; bits 4k+1..4k+3 SHALL be 0.
REQ-025 In MAX, max_out SHALL equal slot[rd_slot]; in SINGLE and GAP, max_out SHALL be 0.
REQ-026 Outputs SHALL use slot contents as held before the current edge; a store to rd_slot becomes visible one cycle after store_ack.
REQ-027 hit SHALL be registered 1 iff state is MAX (after transition) and cnt_in equals slot[rd_slot] on all digits.
REQ-028 store SHALL be accepted iff every digit of cnt_in is <= 9; accept writes limit, sets valid, pulses store_ack next cycle.
REQ-029 A store with any digit > 9 SHALL leave the slot unchanged and pulse store_err next cycle.
REQ-030 A store of all-zero cnt_in SHALL be accepted and the slot marked valid.
REQ-031 clear_all SHALL clear all valid bits (limits may stay); with simultaneous store, clear_all wins, no ack/err pulse.
REQ-032 store_ack and store_err SHALL never be high together and SHALL be high for exactly one cycle per request.
REQ-033 Changing rd_slot while in CARRY/MAX to a valid slot SHALL update max_out next cycle without leaving the mode.

Reset
REQ-034 rst_n low SHALL immediately force state SINGLE, all slots invalid, all limits 0, all outputs 0.
REQ-035 Reset mid-store SHALL discard the store; no ack/err pulse after release.
REQ-036 First rising edge after rst_n rises SHALL evaluate inputs normally.

Verification
REQ-037 Reset, store cnt_in=0x000509 to slot 1, rd_slot=1, mode_req=10 -> store_ack 1 cycle, then max_en=1, max_out=0x000509.
REQ-038 Same slot, mode_req=01 -> one GAP cycle (enables 0, max_out 0), then carry_en=1, max_out=0x000101.
REQ-039 store cnt_in=0x00A123 -> store_err 1 cycle, slot unchanged, no ack.
REQ-040 mode_req=10 with rd_slot=2 unwritten -> mode_err=1, max_en=0, max_out=0; store to slot 2 -> max_en=1 the cycle after ack.
REQ-041 MAX on limit 0x000509, cnt_in steps 0x000508 -> 0x000509 -> hit low then high one cycle later; clear_all -> SINGLE, hit=0.
REQ-042 rst_n low mid-MAX with store asserted -> all outputs 0 at once; after release no ack, mode_err=1 if mode_req=10.
